tl_cpl_rcv: RTL and testbench
=============================

Name: tl_cpl_rcv

Overview:
Requester-side completion receiver; the counterpart of the completion generator. It allocates tags for outgoing non-posted requests and keeps an outstanding-tag table. Incoming Cpl/CplD headers are matched against that table, CplD payload is forwarded to the user, and tags retire on the final completion. It also reports unexpected completions and completion timeouts. It sits between the RX TLP parser (completion path) and the user read-response interface.

Parameters:
TAG_W, 5, tag width; NUM_TAGS = 2**TAG_W outstanding requests
DATA_W, 256, payload beat width (8 DW per beat)
TICK_CYC, 16384, prescaler period in clk cycles for the timeout age tick

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
requester_id_i  in  16  own ID; must equal the header Requester ID
req_alloc_valid_i  in  1  request generator wants a tag
req_alloc_ready_o  out  1  a free tag exists
req_alloc_tag_o  out  TAG_W  tag granted (lowest free)
cpl_hdr_i  in  128  completion header
cpl_hdr_valid_i  in  1  header valid
cpl_hdr_ready_o  out  1  header accepted
cpl_data_i  in  DATA_W  payload beat
cpl_data_valid_i  in  1  beat valid
cpl_data_ready_o  out  1  beat accepted
rsp_valid_o  out  1  response beat valid
rsp_ready_i  in  1  user accepts beat
rsp_tag_o  out  TAG_W  tag of response
rsp_status_o  out  3  completion status (0=SC, 1=UR, 4=CA)
rsp_data_o  out  DATA_W  payload (0 for status-only)
rsp_last_o  out  1  final beat of final completion for this tag
err_unexp_o  out  1  1-cycle pulse: unexpected completion dropped
err_timeout_valid_o  out  1  timeout report valid (one tag per cycle)
err_timeout_tag_o  out  TAG_W  timed-out tag

Behaviour:
- Reset: all outputs 0; tag table empty; state S_IDLE; prescaler and ages 0.
- Header fields: [127:120] 0x4A CplD / 0x0A Cpl; [105:96] length in DW (0 means 1024); [79:77] status; [75:64] byte count; [63:48] requester ID; [47:40] tag (low TAG_W bits used; upper bits must be 0).
- Allocation: req_alloc_ready_o = any tag free. On valid&&ready, the lowest free tag is marked busy with age 0 in the same edge. A tag is never granted while busy.
- FSM states:
  - S_IDLE: cpl_hdr_ready_o=1. On handshake, register the header and go to S_CHECK.
  - S_CHECK (1 cycle): match = tag busy && requester ID equal && upper tag bits 0 && fmt/type in {0x4A, 0x0A}.
    - match && CplD && status==0 -> S_DATA; beats = ceil(len/8).
    - match && Cpl -> S_RSP.
    - no match or CplD with status!=0 -> pulse err_unexp_o; if CplD -> S_DROP, else S_IDLE.
  - S_DATA: rsp_valid_o=cpl_data_valid_i; cpl_data_ready_o=rsp_ready_i; tag and status=0 driven from the registered header. Beat counter increments on each handshake. Final completion is byte_count <= len*4. rsp_last_o = last beat && final. After the last beat: retire the tag if final, then go to S_IDLE.
  - S_RSP: status-only beat; rsp_valid_o=1, rsp_last_o=1, rsp_data_o=0. On rsp_ready_i, retire the tag (any status) and go to S_IDLE.
  - S_DROP: cpl_data_ready_o=1; consume the beat count, then go to S_IDLE. No rsp output.
- Latency: header accept to first rsp_valid_o is 2 cycles minimum. Back-to-back completions cost 1 idle cycle between them.
- Timeout:
  - Prescaler wraps every TICK_CYC cycles.
  - On each tick, every busy tag's 2-bit age saturating-increments. Age 3 marks the tag expired, so timeout falls between 2 and 3 ticks after allocation.
  - The lowest expired tag is reported via err_timeout_valid_o/tag, one per cycle, and freed in the same cycle.
  - Any accepted completion (match) resets that tag's age to 0.
- Simultaneous events:
  - Retire and expire of the same tag in one cycle: retire wins, no timeout report.
  - Alloc and retire of different tags in one cycle both take effect.
  - A tag freed by timeout while its completion is in S_DATA still completes the beats, but is not re-retired.
- Reset mid-operation clears all state; in-flight beats are discarded.

Decomposition:
- tl_pkg additions: cpl_hdr_t packed struct for the 128-bit layout, FMT_CPL/FMT_CPLD constants, tl_cpl_status_e (SC=0, UR=1, CA=4), cpl_rcv_state_e.
- Sub-module tl_tag_table: busy bits, ages, lowest-free and lowest-expired priority encoders, alloc/retire/touch ports.

Test Plan:
- Alloc 3 tags -> granted 0, 1, 2. CplD tag 1, len 16, bc 64, 2 beats -> rsp beats with tag 1, last on beat 2; tag 1 free again, next alloc grants 1.
- Split read: tag 0, CplD len 8 bc 64 then len 8 bc 32 -> first has rsp_last_o=0, second rsp_last_o=1; tag retires only after the second.
- Cpl status UR (1) on tag 2 -> single rsp beat, status 1, data 0, last 1; tag 2 freed.
- CplD on free tag 7, len 8 -> err_unexp_o pulse, 1 beat dropped with cpl_data_ready_o=1, no rsp_valid_o.
- TICK_CYC=16, alloc tag 0, no completion -> err_timeout_valid_o with tag 0 after 33..48 cycles; a later CplD on tag 0 flags err_unexp_o.
- Fill all 32 tags -> req_alloc_ready_o=0. Hold rsp_ready_i=0 during S_DATA -> cpl_data_ready_o=0 and no beat lost; assert rst_n mid-burst -> all outputs 0, table empty.

Source files
------------

// File: rtl/tl_pkg.sv
// ----------------------------------------------------------------------------
// tl_pkg: shared completion-path types and constants.          Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tl_pkg;

  localparam logic [7:0] FMT_CPL  = 8'h0A;
  localparam logic [7:0] FMT_CPLD = 8'h4A;

  typedef enum logic [2:0] {
    CPL_SC = 3'd0,
    CPL_UR = 3'd1,
    CPL_CA = 3'd4
  } tl_cpl_status_e;

  typedef struct packed {
    logic [7:0]  fmt_type;
    logic [13:0] rsvd0;
    logic [9:0]  length;
    logic [15:0] completer_id;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byte_count;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [39:0] rsvd1;
  } cpl_hdr_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DATA  = 3'd2,
    S_RSP   = 3'd3,
    S_DROP  = 3'd4
  } cpl_rcv_state_e;

  // A zero length field encodes the maximum of 1024 DW.
  function automatic logic [10:0] len_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_tag_table.sv
// ----------------------------------------------------------------------------
// tl_tag_table: outstanding-tag busy bits, ages and priority encoders. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tl_tag_table #(
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic                  alloc_i,
  input  logic                  retire_i,
  input  logic [TAG_W-1:0]      retire_tag_i,
  input  logic                  touch_i,
  input  logic [TAG_W-1:0]      touch_tag_i,
  output logic [2**TAG_W-1:0]   busy_o,
  output logic                  free_any_o,
  output logic [TAG_W-1:0]      free_tag_o,
  output logic                  exp_valid_o,
  output logic [TAG_W-1:0]      exp_tag_o
);

  localparam int NUM_TAGS = 2**TAG_W;

  logic [NUM_TAGS-1:0] age_max;
  logic [NUM_TAGS-1:0] retire_oh;
  logic [NUM_TAGS-1:0] touch_oh;
  logic [NUM_TAGS-1:0] exp_vec;

  // A tag being retired or touched this cycle must not also be reported as expired.
  assign exp_vec = busy_o & age_max & ~retire_oh & ~touch_oh;

  always_comb begin
    free_any_o = 1'b0;
    free_tag_o = '0;
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (!busy_o[i]) begin
        free_any_o = 1'b1;
        free_tag_o = TAG_W'(i);
      end
    end
  end

  always_comb begin
    exp_valid_o = 1'b0;
    exp_tag_o   = '0;
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (exp_vec[i]) begin
        exp_valid_o = 1'b1;
        exp_tag_o   = TAG_W'(i);
      end
    end
  end

  for (genvar t = 0; t < NUM_TAGS; t++) begin : g_tag
    logic       busy_q;
    logic [1:0] age_q;
    logic       alloc_hit;
    logic       exp_hit;

    assign retire_oh[t] = retire_i && (retire_tag_i == TAG_W'(t));
    assign touch_oh[t]  = touch_i  && (touch_tag_i  == TAG_W'(t));
    assign alloc_hit    = alloc_i && free_any_o && (free_tag_o == TAG_W'(t));
    assign exp_hit      = exp_valid_o && (exp_tag_o == TAG_W'(t));
    assign busy_o[t]    = busy_q;
    assign age_max[t]   = (age_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_q <= 1'b0;
        age_q  <= 2'd0;
      end else if (alloc_hit) begin
        busy_q <= 1'b1;
        age_q  <= 2'd0;
      end else if (retire_oh[t] || exp_hit) begin
        busy_q <= 1'b0;
        age_q  <= 2'd0;
      end else if (touch_oh[t]) begin
        age_q  <= 2'd0;
      end else if (tick_i && busy_q && (age_q != 2'd3)) begin
        age_q  <= age_q + 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_cpl_rcv.sv
// ----------------------------------------------------------------------------
// tl_cpl_rcv: requester-side completion receiver with tag table and timeout. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tl_cpl_rcv
  import tl_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 256,
  parameter int TICK_CYC = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       requester_id_i,
  input  logic              req_alloc_valid_i,
  output logic              req_alloc_ready_o,
  output logic [TAG_W-1:0]  req_alloc_tag_o,
  input  logic [127:0]      cpl_hdr_i,
  input  logic              cpl_hdr_valid_i,
  output logic              cpl_hdr_ready_o,
  input  logic [DATA_W-1:0] cpl_data_i,
  input  logic              cpl_data_valid_i,
  output logic              cpl_data_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [2:0]        rsp_status_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              err_unexp_o,
  output logic              err_timeout_valid_o,
  output logic [TAG_W-1:0]  err_timeout_tag_o
);

  localparam int NUM_TAGS = 2**TAG_W;
  localparam int PS_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  cpl_rcv_state_e      state_q, state_d;
  cpl_hdr_t            hdr_q, hdr_d;
  logic [7:0]          beat_q, beat_d;
  logic                lost_q, lost_d;
  logic                run_q;
  logic [PS_W-1:0]     ps_q;
  logic                tick;

  logic [NUM_TAGS-1:0] busy;
  logic                free_any;
  logic [TAG_W-1:0]    free_tag;
  logic                exp_valid;
  logic [TAG_W-1:0]    exp_tag;
  logic                alloc;
  logic                retire;
  logic                touch;

  logic [TAG_W-1:0]    cur_tag;
  logic [10:0]         len_words;
  logic [7:0]          num_beats;
  logic                is_cpl;
  logic                is_cpld;
  logic                upper_ok;
  logic                match;
  logic                final_cpl;
  logic                last_beat;
  logic                unused_hdr;

  assign tick = (ps_q == PS_W'(TICK_CYC - 1));

  assign cur_tag   = hdr_q.tag[TAG_W-1:0];
  assign len_words = len_dw(hdr_q.length);
  assign num_beats = 8'((len_words + 11'd7) >> 3);
  assign is_cpl    = (hdr_q.fmt_type == FMT_CPL);
  assign is_cpld   = (hdr_q.fmt_type == FMT_CPLD);
  assign upper_ok  = ((hdr_q.tag >> TAG_W) == 8'd0);
  assign match     = busy[cur_tag] && (hdr_q.requester_id == requester_id_i) &&
                     upper_ok && (is_cpl || is_cpld);
  assign final_cpl = ({1'b0, hdr_q.byte_count} <= {len_words, 2'b00});
  assign last_beat = (beat_q == num_beats - 8'd1);
  assign unused_hdr = ^{hdr_q.rsvd0, hdr_q.completer_id, hdr_q.bcm, hdr_q.rsvd1};

  // Allocation and header acceptance stay low until the first edge after reset.
  assign req_alloc_ready_o   = run_q && free_any;
  assign req_alloc_tag_o     = free_tag;
  assign alloc               = req_alloc_valid_i && req_alloc_ready_o;
  assign err_timeout_valid_o = exp_valid;
  assign err_timeout_tag_o   = exp_tag;

  tl_tag_table #(
    .TAG_W (TAG_W)
  ) u_tag_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick),
    .alloc_i      (alloc),
    .retire_i     (retire),
    .retire_tag_i (cur_tag),
    .touch_i      (touch),
    .touch_tag_i  (cur_tag),
    .busy_o       (busy),
    .free_any_o   (free_any),
    .free_tag_o   (free_tag),
    .exp_valid_o  (exp_valid),
    .exp_tag_o    (exp_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      beat_q  <= '0;
      lost_q  <= 1'b0;
      run_q   <= 1'b0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      beat_q  <= beat_d;
      lost_q  <= lost_d;
      run_q   <= 1'b1;
      ps_q    <= tick ? '0 : ps_q + 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    hdr_d            = hdr_q;
    beat_d           = beat_q;
    lost_d           = lost_q;
    cpl_hdr_ready_o  = 1'b0;
    cpl_data_ready_o = 1'b0;
    rsp_valid_o      = 1'b0;
    rsp_tag_o        = '0;
    rsp_status_o     = 3'd0;
    rsp_data_o       = '0;
    rsp_last_o       = 1'b0;
    err_unexp_o      = 1'b0;
    retire           = 1'b0;
    touch            = 1'b0;

    // A tag that times out mid-response keeps streaming but must not be retired twice.
    if ((state_q == S_DATA || state_q == S_RSP) && exp_valid && (exp_tag == cur_tag)) begin
      lost_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cpl_hdr_ready_o = run_q;
        if (cpl_hdr_valid_i && run_q) begin
          hdr_d   = cpl_hdr_t'(cpl_hdr_i);
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        beat_d = '0;
        lost_d = 1'b0;
        if (match && is_cpld && (hdr_q.status == 3'(CPL_SC))) begin
          touch   = 1'b1;
          state_d = S_DATA;
        end else if (match && is_cpl) begin
          touch   = 1'b1;
          state_d = S_RSP;
        end else begin
          err_unexp_o = 1'b1;
          state_d     = is_cpld ? S_DROP : S_IDLE;
        end
      end

      S_DATA: begin
        rsp_valid_o      = cpl_data_valid_i;
        cpl_data_ready_o = rsp_ready_i;
        rsp_tag_o        = cur_tag;
        rsp_data_o       = cpl_data_i;
        rsp_last_o       = last_beat && final_cpl;
        if (cpl_data_valid_i && rsp_ready_i) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            retire  = final_cpl && !lost_q;
            state_d = S_IDLE;
          end
        end
      end

      S_RSP: begin
        rsp_valid_o  = 1'b1;
        rsp_last_o   = 1'b1;
        rsp_tag_o    = cur_tag;
        rsp_status_o = hdr_q.status;
        if (rsp_ready_i) begin
          retire  = !lost_q;
          state_d = S_IDLE;
        end
      end

      S_DROP: begin
        cpl_data_ready_o = 1'b1;
        if (cpl_data_valid_i) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tl_cpl_rcv.sv
// ----------------------------------------------------------------------------
// tb_tl_cpl_rcv: scoreboard bench for the completion receiver.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tl_cpl_rcv;

  localparam int TAG_W    = 5;
  localparam int DATA_W   = 256;
  localparam int TICK_CYC = 16;
  localparam logic [15:0] MY_ID  = 16'h0123;
  localparam logic [7:0]  F_CPL  = 8'h0A;
  localparam logic [7:0]  F_CPLD = 8'h4A;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [2:0]        status;
    logic [DATA_W-1:0] data;
    logic              last;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_alloc_valid_i = 1'b0;
  logic              req_alloc_ready_o;
  logic [TAG_W-1:0]  req_alloc_tag_o;
  logic [127:0]      cpl_hdr_i = '0;
  logic              cpl_hdr_valid_i = 1'b0;
  logic              cpl_hdr_ready_o;
  logic [DATA_W-1:0] cpl_data_i = '0;
  logic              cpl_data_valid_i = 1'b0;
  logic              cpl_data_ready_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic [2:0]        rsp_status_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_last_o;
  logic              err_unexp_o;
  logic              err_timeout_valid_o;
  logic [TAG_W-1:0]  err_timeout_tag_o;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_unexp = 0;
  int   n_to = 0;

  always #5 clk = ~clk;

  tl_cpl_rcv #(
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W),
    .TICK_CYC (TICK_CYC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .requester_id_i      (MY_ID),
    .req_alloc_valid_i   (req_alloc_valid_i),
    .req_alloc_ready_o   (req_alloc_ready_o),
    .req_alloc_tag_o     (req_alloc_tag_o),
    .cpl_hdr_i           (cpl_hdr_i),
    .cpl_hdr_valid_i     (cpl_hdr_valid_i),
    .cpl_hdr_ready_o     (cpl_hdr_ready_o),
    .cpl_data_i          (cpl_data_i),
    .cpl_data_valid_i    (cpl_data_valid_i),
    .cpl_data_ready_o    (cpl_data_ready_o),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_tag_o           (rsp_tag_o),
    .rsp_status_o        (rsp_status_o),
    .rsp_data_o          (rsp_data_o),
    .rsp_last_o          (rsp_last_o),
    .err_unexp_o         (err_unexp_o),
    .err_timeout_valid_o (err_timeout_valid_o),
    .err_timeout_tag_o   (err_timeout_tag_o)
  );

  task automatic check(input string name, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [7:0] fmt, input logic [9:0] len,
                                          input logic [2:0] st, input logic [11:0] bc,
                                          input logic [15:0] rid, input logic [7:0] tag);
    logic [127:0] h;
    h           = '0;
    h[127:120]  = fmt;
    h[105:96]   = len;
    h[95:80]    = 16'hBEEF;
    h[79:77]    = st;
    h[75:64]    = bc;
    h[63:48]    = rid;
    h[47:40]    = tag;
    return h;
  endfunction

  // Response monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", word_t'(rsp_valid_o), word_t'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_tag",    word_t'(rsp_tag_o),    word_t'(mon_e.tag));
          check("rsp_status", word_t'(rsp_status_o), word_t'(mon_e.status));
          check("rsp_data",   rsp_data_o,            mon_e.data);
          check("rsp_last",   word_t'(rsp_last_o),   word_t'(mon_e.last));
        end
      end
      if (err_unexp_o) n_unexp++;
      if (err_timeout_valid_o) n_to++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_alloc_valid_i = 1'b0;
    cpl_hdr_valid_i   = 1'b0;
    cpl_data_valid_i  = 1'b0;
    rsp_ready_i       = 1'b1;
    @(negedge clk);
    check("rst_ctl", word_t'({req_alloc_ready_o, req_alloc_tag_o, cpl_hdr_ready_o,
                              cpl_data_ready_o, rsp_valid_o, rsp_tag_o, rsp_status_o,
                              rsp_last_o, err_unexp_o, err_timeout_valid_o,
                              err_timeout_tag_o}), word_t'(0));
    check("rst_data", rsp_data_o, word_t'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
  endtask

  task automatic do_alloc(output logic [TAG_W-1:0] t);
    int w = 0;
    req_alloc_valid_i = 1'b1;
    @(negedge clk);
    while (!req_alloc_ready_o && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) check("alloc_timeout", word_t'(req_alloc_ready_o), word_t'(1));
    t = req_alloc_tag_o;
    @(posedge clk);
    #1 req_alloc_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [127:0] h);
    int w = 0;
    cpl_hdr_i       = h;
    cpl_hdr_valid_i = 1'b1;
    @(negedge clk);
    while (!cpl_hdr_ready_o && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) check("hdr_timeout", word_t'(cpl_hdr_ready_o), word_t'(1));
    @(posedge clk);
    #1 cpl_hdr_valid_i = 1'b0;
  endtask

  task automatic send_beat(input bit push, input logic [TAG_W-1:0] tag, input logic last);
    word_t d;
    int    w = 0;
    d = {8{$urandom}};
    if (push) exp_q.push_back('{tag: tag, status: 3'd0, data: d, last: last});
    cpl_data_i       = d;
    cpl_data_valid_i = 1'b1;
    @(negedge clk);
    while (!cpl_data_ready_o && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) check("beat_timeout", word_t'(cpl_data_ready_o), word_t'(1));
    @(posedge clk);
    #1 cpl_data_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("drain", word_t'(exp_q.size()), word_t'(0));
    tick(1);
  endtask

  initial begin
    logic [TAG_W-1:0] t;
    int u0;
    int n;
    word_t d;

    // Basic CplD: allocate three tags, two-beat completion on tag 1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_alloc(t);
      check("alloc_seq", word_t'(t), word_t'(i));
    end
    send_hdr(mk_hdr(F_CPLD, 10'd16, 3'd0, 12'd64, MY_ID, 8'd1));
    send_beat(1'b1, 5'd1, 1'b0);
    send_beat(1'b1, 5'd1, 1'b1);
    wait_drain();
    do_alloc(t);
    check("realloc_tag1", word_t'(t), word_t'(1));

    // Split read on tag 0: first piece not final, second retires the tag.
    do_reset();
    do_alloc(t);
    check("split_alloc0", word_t'(t), word_t'(0));
    send_hdr(mk_hdr(F_CPLD, 10'd8, 3'd0, 12'd64, MY_ID, 8'd0));
    send_beat(1'b1, 5'd0, 1'b0);
    wait_drain();
    do_alloc(t);
    check("split_still_busy", word_t'(t), word_t'(1));
    send_hdr(mk_hdr(F_CPLD, 10'd8, 3'd0, 12'd32, MY_ID, 8'd0));
    send_beat(1'b1, 5'd0, 1'b1);
    wait_drain();
    do_alloc(t);
    check("split_retired", word_t'(t), word_t'(0));

    // Status-only UR completion on tag 2.
    do_reset();
    repeat (3) do_alloc(t);
    exp_q.push_back('{tag: 5'd2, status: 3'd1, data: '0, last: 1'b1});
    send_hdr(mk_hdr(F_CPL, 10'd0, 3'd1, 12'd4, MY_ID, 8'd2));
    wait_drain();
    do_alloc(t);
    check("ur_freed", word_t'(t), word_t'(2));

    // Unexpected CplD on free tag 7: pulse, drop one beat, no response.
    do_reset();
    u0 = n_unexp;
    send_hdr(mk_hdr(F_CPLD, 10'd8, 3'd0, 12'd32, MY_ID, 8'd7));
    cpl_data_i       = {8{$urandom}};
    cpl_data_valid_i = 1'b1;
    @(negedge clk);
    check("unexp_pulse", word_t'(err_unexp_o), word_t'(1));
    @(negedge clk);
    check("drop_ready", word_t'(cpl_data_ready_o), word_t'(1));
    check("drop_no_rsp", word_t'(rsp_valid_o), word_t'(0));
    @(posedge clk);
    #1 cpl_data_valid_i = 1'b0;
    @(negedge clk);
    check("drop_back_idle", word_t'(cpl_hdr_ready_o), word_t'(1));
    check("unexp_count", word_t'(n_unexp - u0), word_t'(1));
    tick(1);

    // Timeout: tag 0 never completes.
    do_reset();
    u0 = n_to;
    do_alloc(t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout_valid_o && n < 80);
    check("to_valid", word_t'(err_timeout_valid_o), word_t'(1));
    check("to_tag", word_t'(err_timeout_tag_o), word_t'(0));
    check("to_latency_33_48", word_t'(n >= 33 && n <= 48), word_t'(1));
    @(negedge clk);
    check("to_single", word_t'(err_timeout_valid_o), word_t'(0));
    check("to_count", word_t'(n_to - u0), word_t'(1));
    tick(1);
    u0 = n_unexp;
    send_hdr(mk_hdr(F_CPLD, 10'd8, 3'd0, 12'd32, MY_ID, 8'd0));
    send_beat(1'b0, 5'd0, 1'b0);
    tick(1);
    check("to_late_unexp", word_t'(n_unexp - u0), word_t'(1));

    // Fill the table.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      do_alloc(t);
      check("fill_tag", word_t'(t), word_t'(i));
    end
    @(negedge clk);
    check("fill_not_ready", word_t'(req_alloc_ready_o), word_t'(0));

    // Back-pressure during S_DATA.
    do_reset();
    do_alloc(t);
    rsp_ready_i = 1'b0;
    send_hdr(mk_hdr(F_CPLD, 10'd16, 3'd0, 12'd64, MY_ID, 8'd0));
    d = {8{$urandom}};
    exp_q.push_back('{tag: 5'd0, status: 3'd0, data: d, last: 1'b0});
    cpl_data_i       = d;
    cpl_data_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_data_ready", word_t'(cpl_data_ready_o), word_t'(0));
    end
    check("bp_rsp_valid", word_t'(rsp_valid_o), word_t'(1));
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release", word_t'(cpl_data_ready_o), word_t'(1));
    @(posedge clk);
    #1 cpl_data_valid_i = 1'b0;
    send_beat(1'b1, 5'd0, 1'b1);
    wait_drain();
    do_alloc(t);
    check("bp_retired", word_t'(t), word_t'(0));

    // Reset in the middle of a burst.
    do_reset();
    do_alloc(t);
    do_alloc(t);
    send_hdr(mk_hdr(F_CPLD, 10'd16, 3'd0, 12'd64, MY_ID, 8'd1));
    send_beat(1'b1, 5'd1, 1'b0);
    cpl_data_i       = {8{$urandom}};
    cpl_data_valid_i = 1'b1;
    rst_n            = 1'b0;
    @(negedge clk);
    check("mid_rst_ctl", word_t'({req_alloc_ready_o, cpl_hdr_ready_o, cpl_data_ready_o,
                                  rsp_valid_o, rsp_last_o, err_unexp_o,
                                  err_timeout_valid_o}), word_t'(0));
    check("mid_rst_queue", word_t'(exp_q.size()), word_t'(0));
    cpl_data_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    do_alloc(t);
    check("mid_rst_empty0", word_t'(t), word_t'(0));
    do_alloc(t);
    check("mid_rst_empty1", word_t'(t), word_t'(1));

    check("total_unexp", word_t'(n_unexp), word_t'(2));
    check("total_timeouts", word_t'(n_to), word_t'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
